// File: rtl/sys_cas_loader.sv
// ---------------------------------------------------------------------------
// sys_cas_loader
//
// Parses a SYSTEM-format CAS image arriving over the ioctl download port and
// turns it into RAM writes. The image is a run of 0x00 leader bytes, the
// magic pair A5 55, a 6-byte name, then any number of data blocks
// (3C len addrL addrH data... csum) and an optional entry trailer
// (78 entL entH). When the download ends after a complete trailer, a
// one-cycle execute_enable pulse starts the loaded program.
//
// Optional feature: define SYS_CAS_LOADER_CKSUM_EN to check every block
// checksum (8-bit sum of addrL, addrH and the data bytes). Without it the
// checksum byte is consumed unchecked and cksum_err is constant 0.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   ioctl_download          download in progress
//   ioctl_wr / ioctl_dout   byte strobe and byte
//   ioctl_index             file index; only INDEX is handled here
//   ioctl_wait              holds off the next ioctl_wr for one cycle
//   loader_wr               one-cycle RAM write strobe
//   loader_download         loader owns the RAM download path
//   loader_addr/loader_data RAM write address / data
//   execute_addr            program entry address from the trailer
//   execute_enable          one-cycle program start pulse
//   cksum_err               sticky block-checksum mismatch
//   fmt_err                 sticky format error
// ---------------------------------------------------------------------------
module sys_cas_loader #(
    parameter logic [7:0] INDEX = 8'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        loader_wr,
    output logic        loader_download,
    output logic [15:0] loader_addr,
    output logic [7:0]  loader_data,
    output logic [15:0] execute_addr,
    output logic        execute_enable,
    output logic        cksum_err,
    output logic        fmt_err
);

    typedef enum logic [3:0] {
        IDLE, LEADER, MAGIC, NAME, BTYPE, LEN, ADDRL,
        ADDRH, DATA, CSUM, ENTL, ENTH, DONE, ERR
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       active;
    logic       armed;
    logic       rise;
    logic       fall;
    logic       accept;
    logic       entry_seen;
    logic [2:0] name_cnt;
    logic [8:0] blk_cnt;

    assign active = ioctl_download && (ioctl_index == INDEX);

    // loader_download is the registered session flag, so it doubles as the
    // previous value of active for edge detection. "armed" only becomes set
    // once active has been seen low, so a reset in the middle of a download
    // does not treat the still-high download as a new rising edge.
    assign rise   = active && armed && !loader_download;
    assign fall   = loader_download && !active;
    assign accept = ioctl_wr && active && loader_download;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the falling edge of the session wins over any byte
    always_comb begin
        next_state = state;
        if (fall) begin
            next_state = IDLE;
        end else if (state == IDLE) begin
            if (rise) begin
                next_state = LEADER;
            end
        end else if (accept) begin
            case (state)
                LEADER: begin
                    if (ioctl_dout == 8'hA5) begin
                        next_state = MAGIC;
                    end else if (ioctl_dout != 8'h00) begin
                        next_state = ERR;
                    end
                end
                MAGIC:  next_state = (ioctl_dout == 8'h55) ? NAME : ERR;
                NAME: begin
                    if (name_cnt == 3'd5) begin
                        next_state = BTYPE;
                    end
                end
                BTYPE: begin
                    if (ioctl_dout == 8'h3C) begin
                        next_state = LEN;
                    end else if (ioctl_dout == 8'h78) begin
                        next_state = ENTL;
                    end else begin
                        next_state = ERR;
                    end
                end
                LEN:    next_state = ADDRL;
                ADDRL:  next_state = ADDRH;
                ADDRH:  next_state = DATA;
                DATA: begin
                    if (blk_cnt == 9'd1) begin
                        next_state = CSUM;
                    end
                end
                CSUM:   next_state = BTYPE;
                ENTL:   next_state = ENTH;
                ENTH:   next_state = DONE;
                default: next_state = state;
            endcase
        end
    end

    // Datapath: session tracking, handshake, RAM write port and trailer.
    // loader_addr advances on the cycle the write strobe is out, so each
    // write uses the address it was loaded or incremented to beforehand.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed           <= 1'b0;
            loader_download <= 1'b0;
            ioctl_wait      <= 1'b0;
            loader_wr       <= 1'b0;
            loader_addr     <= 16'h0000;
            loader_data     <= 8'h00;
            execute_addr    <= 16'h0000;
            execute_enable  <= 1'b0;
            entry_seen      <= 1'b0;
            fmt_err         <= 1'b0;
            name_cnt        <= 3'd0;
            blk_cnt         <= 9'd0;
        end else begin
            armed           <= armed || !active;
            loader_download <= active && armed;
            ioctl_wait      <= accept;
            loader_wr       <= accept && (state == DATA);
            execute_enable  <= fall && (state == DONE) && entry_seen;

            if (loader_wr) begin
                loader_addr <= loader_addr + 16'd1;
            end

            if (rise) begin
                fmt_err    <= 1'b0;
                entry_seen <= 1'b0;
            end

            if (accept && (state != ERR) && (next_state == ERR)) begin
                fmt_err <= 1'b1;
            end

            if (accept) begin
                case (state)
                    MAGIC: name_cnt <= 3'd0;
                    NAME:  name_cnt <= name_cnt + 3'd1;
                    LEN:   blk_cnt  <= (ioctl_dout == 8'h00) ? 9'd256 : {1'b0, ioctl_dout};
                    ADDRL: loader_addr[7:0]  <= ioctl_dout;
                    ADDRH: loader_addr[15:8] <= ioctl_dout;
                    DATA: begin
                        loader_data <= ioctl_dout;
                        blk_cnt     <= blk_cnt - 9'd1;
                    end
                    ENTL:  execute_addr[7:0] <= ioctl_dout;
                    ENTH: begin
                        execute_addr[15:8] <= ioctl_dout;
                        entry_seen         <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SYS_CAS_LOADER_CKSUM_EN
    logic [7:0] sum;

    // Running block checksum; a mismatch is recorded but parsing continues
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum       <= 8'h00;
            cksum_err <= 1'b0;
        end else begin
            if (rise) begin
                cksum_err <= 1'b0;
            end
            if (accept) begin
                case (state)
                    ADDRL:       sum <= ioctl_dout;
                    ADDRH, DATA: sum <= sum + ioctl_dout;
                    CSUM: begin
                        if (ioctl_dout != sum) begin
                            cksum_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    assign cksum_err = 1'b0;
`endif

endmodule
